// File: rtl/dm_access_ctrl_if.sv
// Pipeline-side request/response bus of the data-memory access controller.
// The pipeline drives the master modport; the controller uses the slave modport.
interface dm_access_ctrl_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] vaddr;
    logic [31:0] wdata;
    logic        ready;
    logic        done;
    logic [31:0] rdata;
    logic        adel;
    logic        ades;
    logic [31:0] badvaddr;

    modport master (
        output req, wr, size, uns, vaddr, wdata,
        input  ready, done, rdata, adel, ades, badvaddr
    );

    modport slave (
        input  req, wr, size, uns, vaddr, wdata,
        output ready, done, rdata, adel, ades, badvaddr
    );
endinterface

// File: rtl/dm_access_ctrl.sv
// Data-memory access controller: one request at a time, byte/half/word loads and
// stores with lane enables, load extension and address-error reporting.
module dm_access_ctrl (
    input  logic               clk,
    input  logic               rst,
    dm_access_ctrl_if.slave    pipe,
    output logic [9:0]         addr,
    output logic [3:0]         be,
    output logic [31:0]        din,
    output logic               DMWr,
    input  logic [31:0]        dout
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2,
        FAULT  = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic        accept_s;

    logic        wr_r;
    logic [1:0]  size_r;
    logic        uns_r;
    logic [1:0]  off_r;
    logic        ready_r;
    logic        done_r;
    logic        adel_r;
    logic        ades_r;
    logic [31:0] rdata_r;
    logic [31:0] badvaddr_r;
    logic [9:0]  addr_r;
    logic [3:0]  be_r;
    logic [31:0] din_r;
    logic        wr_access_r;

    function automatic logic is_aligned(input logic [1:0] sz, input logic [1:0] off);
        logic ok;
        case (sz)
            2'b00:   ok = 1'b1;
            2'b01:   ok = ~off[0];
            2'b10:   ok = (off == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] lane_enables(input logic [1:0] sz, input logic [1:0] off);
        logic [3:0] lanes;
        case (sz)
            2'b00:   lanes = 4'b0001 << off;
            2'b01:   lanes = off[1] ? 4'b1100 : 4'b0011;
            2'b10:   lanes = 4'b1111;
            default: lanes = 4'b0000;
        endcase
        return lanes;
    endfunction

    function automatic logic [31:0] extract_load(input logic [31:0] word, input logic [1:0] sz,
                                                 input logic [1:0] off, input logic zext);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (sz)
            2'b00:   r = zext ? {24'h000000, b} : {{24{b[7]}}, b};
            2'b01:   r = zext ? {16'h0000, h} : {{16{h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Next-state decode; misaligned or illegal-size requests divert to FAULT.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (pipe.req) begin
                    accept_s     = 1'b1;
                    state_next_s = is_aligned(pipe.size, pipe.vaddr[1:0]) ? ACCESS : FAULT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ACCESS:  state_next_s = RESP;
            RESP:    state_next_s = IDLE;
            FAULT:   state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State, request latches and registered outputs decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            wr_r        <= 1'b0;
            size_r      <= 2'b00;
            uns_r       <= 1'b0;
            off_r       <= 2'b00;
            ready_r     <= 1'b1;
            done_r      <= 1'b0;
            adel_r      <= 1'b0;
            ades_r      <= 1'b0;
            rdata_r     <= 32'h0000_0000;
            badvaddr_r  <= 32'h0000_0000;
            addr_r      <= 10'd0;
            be_r        <= 4'b0000;
            din_r       <= 32'h0000_0000;
            wr_access_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            ready_r <= (state_next_s == IDLE);
            done_r  <= (state_next_s == RESP);
            adel_r  <= (state_next_s == FAULT) & ~pipe.wr;
            ades_r  <= (state_next_s == FAULT) & pipe.wr;
            if (accept_s) begin
                wr_r   <= pipe.wr;
                size_r <= pipe.size;
                uns_r  <= pipe.uns;
                off_r  <= pipe.vaddr[1:0];
            end
            // Memory-side bus is live only for the single ACCESS cycle.
            if (state_next_s == ACCESS) begin
                addr_r      <= pipe.vaddr[11:2];
                be_r        <= lane_enables(pipe.size, pipe.vaddr[1:0]);
                din_r       <= pipe.wdata;
                wr_access_r <= pipe.wr;
            end else begin
                addr_r      <= 10'd0;
                be_r        <= 4'b0000;
                din_r       <= 32'h0000_0000;
                wr_access_r <= 1'b0;
            end
            if (state_next_s == FAULT) begin
                badvaddr_r <= pipe.vaddr;
            end
            if (state_r == ACCESS) begin
                rdata_r <= wr_r ? 32'h0000_0000 : extract_load(dout, size_r, off_r, uns_r);
            end
        end
    end

    // Reset gates the strobe in the same cycle so an aborted store never lands.
    assign DMWr          = wr_access_r & ~rst;
    assign addr          = addr_r;
    assign be            = be_r;
    assign din           = din_r;
    assign pipe.ready    = ready_r;
    assign pipe.done     = done_r;
    assign pipe.rdata    = rdata_r;
    assign pipe.adel     = adel_r;
    assign pipe.ades     = ades_r;
    assign pipe.badvaddr = badvaddr_r;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Bench for dm_access_ctrl: byte-addressed reference memory model, directed
// scenarios and randomized load/store traffic.
module tb_dm_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  addr;
    logic [3:0]  be;
    logic [31:0] din;
    logic [31:0] dout;
    logic        DMWr;

    always #5 clk = ~clk;

    dm_access_ctrl_if pipe ();

    dm_access_ctrl dut (
        .clk  (clk),
        .rst  (rst),
        .pipe (pipe),
        .addr (addr),
        .be   (be),
        .din  (din),
        .DMWr (DMWr),
        .dout (dout)
    );

    // Environment memory: word array with lane merging as seen by the controller.
    logic [31:0] mem [0:1023];
    logic        init_en;
    logic [9:0]  init_idx;
    logic [31:0] init_val;

    assign dout = mem[addr];

    always @(posedge clk) begin
        if (init_en) begin
            mem[init_idx] <= init_val;
        end else if (DMWr) begin
            for (int k = 0; k < 4; k++) begin
                if (be[k]) begin
                    if (be == 4'hF)                     mem[addr][8*k +: 8] <= din[8*k +: 8];
                    else if (be == 4'h3 || be == 4'hC)  mem[addr][8*k +: 8] <= din[8*(k%2) +: 8];
                    else                                mem[addr][8*k +: 8] <= din[7:0];
                end
            end
        end
    end

    // Reference model: flat 4 KB byte array plus expected sticky outputs.
    logic [7:0]  ref_mem [0:4095];
    logic [31:0] m_rdata;
    logic [31:0] m_badvaddr;
    int          checks = 0;
    int          errors = 0;

    function automatic logic [31:0] model_load(input logic [1:0] sz, input logic u, input logic [11:0] a);
        int          n;
        logic [31:0] v;
        n = 1 << sz;
        v = 32'h0;
        for (int i = 0; i < n; i++) v = v | ({24'h0, ref_mem[a + i]} << (8 * i));
        if (!u && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    task automatic do_access(input logic w, input logic [1:0] sz, input logic u,
                             input logic [31:0] va, input logic [31:0] wd);
        int          n;
        int          waited;
        logic        fault;
        logic [11:0] a;
        logic [31:0] exp_val;
        logic [3:0]  exp_be;
        a      = va[11:0];
        n      = 1 << sz;
        fault  = (sz == 2'd3) || (sz == 2'd1 && va[0]) || (sz == 2'd2 && va[1:0] != 2'b00);
        exp_be = 4'b0000;
        exp_val = 32'h0;
        if (!fault) begin
            for (int i = 0; i < n; i++) exp_be[a[1:0] + i] = 1'b1;
            exp_val = model_load(sz, u, a);
        end
        @(negedge clk);
        waited = 0;
        while (pipe.ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (pipe.ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_wait got=%b exp=1", pipe.ready);
            return;
        end
        pipe.req   = 1'b1;
        pipe.wr    = w;
        pipe.size  = sz;
        pipe.uns   = u;
        pipe.vaddr = va;
        pipe.wdata = wd;
        @(posedge clk); #1;
        pipe.req = 1'b0;
        if (fault) begin
            m_badvaddr = va;
            checks++;
            if ({pipe.adel, pipe.ades, pipe.done} !== {~w, w, 1'b0}) begin
                errors++;
                $display("FAIL fault_flags va=%h got adel/ades/done=%b%b%b exp=%b%b0",
                         va, pipe.adel, pipe.ades, pipe.done, ~w, w);
            end
            checks++;
            if (pipe.badvaddr !== m_badvaddr) begin
                errors++;
                $display("FAIL badvaddr got=%h exp=%h", pipe.badvaddr, m_badvaddr);
            end
            checks++;
            if ({DMWr, be, addr} !== 15'h0) begin
                errors++;
                $display("FAIL fault_mem_quiet got DMWr=%b be=%b addr=%h exp 0", DMWr, be, addr);
            end
            checks++;
            if (pipe.rdata !== m_rdata) begin
                errors++;
                $display("FAIL rdata_hold got=%h exp=%h", pipe.rdata, m_rdata);
            end
        end else begin
            checks++;
            if ({addr, be, DMWr, pipe.ready, pipe.done} !== {a[11:2], exp_be, w, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL access_bus va=%h got addr=%h be=%b DMWr=%b rdy=%b done=%b exp addr=%h be=%b DMWr=%b",
                         va, addr, be, DMWr, pipe.ready, pipe.done, a[11:2], exp_be, w);
            end
            if (w) begin
                checks++;
                if (din !== wd) begin
                    errors++;
                    $display("FAIL din got=%h exp=%h", din, wd);
                end
            end
            @(posedge clk); #1;
            if (w) begin
                for (int i = 0; i < n; i++) ref_mem[a + i] = wd[8*i +: 8];
                m_rdata = 32'h0;
            end else begin
                m_rdata = exp_val;
            end
            checks++;
            if ({pipe.done, pipe.adel, pipe.ades, DMWr, be} !== {3'b100, 1'b0, 4'b0000}) begin
                errors++;
                $display("FAIL resp_flags got done/adel/ades=%b%b%b DMWr=%b be=%b exp 100 0 0000",
                         pipe.done, pipe.adel, pipe.ades, DMWr, be);
            end
            checks++;
            if (pipe.rdata !== m_rdata) begin
                errors++;
                $display("FAIL rdata va=%h sz=%0d uns=%b got=%h exp=%h", va, sz, u, pipe.rdata, m_rdata);
            end
        end
        @(posedge clk); #1;
        checks++;
        if ({pipe.ready, pipe.done, pipe.adel, pipe.ades} !== 4'b1000) begin
            errors++;
            $display("FAIL idle_return got rdy/done/adel/ades=%b%b%b%b exp=1000",
                     pipe.ready, pipe.done, pipe.adel, pipe.ades);
        end
    endtask

    task automatic expect_rdata(input string name, input logic [31:0] exp);
        checks++;
        if (pipe.rdata !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, pipe.rdata, exp);
        end
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        init_en    = 1'b1;
        pipe.req   = 1'b0;
        pipe.wr    = 1'b0;
        pipe.size  = 2'b00;
        pipe.uns   = 1'b0;
        pipe.vaddr = 32'h0;
        pipe.wdata = 32'h0;
        for (int i = 0; i < 1024; i++) begin
            @(negedge clk);
            init_idx = 10'(i);
            init_val = $urandom;
            for (int b = 0; b < 4; b++) ref_mem[4*i + b] = init_val[8*b +: 8];
        end
        @(negedge clk);
        init_en = 1'b0;
        pipe.req = 1'b1;
        @(posedge clk); #1;
        m_rdata    = 32'h0;
        m_badvaddr = 32'h0;
        checks++;
        if ({pipe.ready, pipe.done, pipe.adel, pipe.ades, DMWr} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_ctrl got rdy/done/adel/ades/DMWr=%b%b%b%b%b exp=10000",
                     pipe.ready, pipe.done, pipe.adel, pipe.ades, DMWr);
        end
        checks++;
        if ({addr, be, din} !== 46'h0) begin
            errors++;
            $display("FAIL reset_bus got addr=%h be=%b din=%h exp 0", addr, be, din);
        end
        checks++;
        if ({pipe.rdata, pipe.badvaddr} !== 64'h0) begin
            errors++;
            $display("FAIL reset_data got rdata=%h badvaddr=%h exp 0", pipe.rdata, pipe.badvaddr);
        end
        @(negedge clk);
        pipe.req = 1'b0;
        rst      = 1'b0;
    endtask

    task automatic test_store_load_word();
        do_access(1'b1, 2'd2, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF);
        do_access(1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0);
        expect_rdata("lw_deadbeef", 32'hDEAD_BEEF);
    endtask

    task automatic test_load_extend();
        do_access(1'b1, 2'd2, 1'b0, 32'h20, 32'h8001_7F80);
        do_access(1'b0, 2'd0, 1'b0, 32'h20, 32'h0);
        expect_rdata("lb_20", 32'hFFFF_FF80);
        do_access(1'b0, 2'd0, 1'b1, 32'h20, 32'h0);
        expect_rdata("lbu_20", 32'h0000_0080);
        do_access(1'b0, 2'd0, 1'b0, 32'h21, 32'h0);
        expect_rdata("lb_21", 32'h0000_007F);
        do_access(1'b0, 2'd1, 1'b0, 32'h22, 32'h0);
        expect_rdata("lh_22", 32'hFFFF_8001);
        do_access(1'b0, 2'd1, 1'b1, 32'h22, 32'h0);
        expect_rdata("lhu_22", 32'h0000_8001);
    endtask

    task automatic test_partial_store();
        do_access(1'b1, 2'd2, 1'b0, 32'h30, 32'h1122_3344);
        do_access(1'b1, 2'd1, 1'b0, 32'h32, 32'h0000_ABCD);
        do_access(1'b0, 2'd2, 1'b0, 32'h30, 32'h0);
        expect_rdata("sh_upper", 32'hABCD_3344);
        do_access(1'b1, 2'd0, 1'b0, 32'h33, 32'h0000_0012);
        do_access(1'b0, 2'd2, 1'b0, 32'h30, 32'h0);
        expect_rdata("sb_lane3", 32'h12CD_3344);
    endtask

    task automatic test_faults();
        do_access(1'b0, 2'd2, 1'b0, 32'h0000_0006, 32'h0);
        do_access(1'b1, 2'd1, 1'b0, 32'h0000_0005, 32'h5555_5555);
        do_access(1'b0, 2'd3, 1'b0, 32'h0000_0040, 32'h0);
        do_access(1'b1, 2'd3, 1'b0, 32'h0000_0044, 32'hFFFF_FFFF);
        do_access(1'b0, 2'd2, 1'b0, 32'h0000_0004, 32'h0);
    endtask

    task automatic test_wrap();
        do_access(1'b1, 2'd2, 1'b0, 32'hFFFF_F048, 32'hCAFE_F00D);
        do_access(1'b0, 2'd2, 1'b0, 32'h0000_0048, 32'h0);
        expect_rdata("wrap_4k", 32'hCAFE_F00D);
    endtask

    task automatic test_reset_in_access();
        logic [31:0] orig;
        orig = model_load(2'd2, 1'b0, 12'h080);
        @(negedge clk);
        pipe.req   = 1'b1;
        pipe.wr    = 1'b1;
        pipe.size  = 2'd2;
        pipe.uns   = 1'b0;
        pipe.vaddr = 32'h80;
        pipe.wdata = ~orig;
        @(posedge clk); #1;
        pipe.req = 1'b0;
        checks++;
        if (DMWr !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre_strobe got=%b exp=1", DMWr);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (DMWr !== 1'b0) begin
            errors++;
            $display("FAIL abort_strobe_gated got=%b exp=0", DMWr);
        end
        @(posedge clk); #1;
        rst        = 1'b0;
        m_rdata    = 32'h0;
        m_badvaddr = 32'h0;
        checks++;
        if ({pipe.ready, pipe.done, pipe.rdata, pipe.badvaddr} !== {1'b1, 1'b0, 64'h0}) begin
            errors++;
            $display("FAIL abort_idle got rdy=%b done=%b rdata=%h badvaddr=%h exp 1 0 0 0",
                     pipe.ready, pipe.done, pipe.rdata, pipe.badvaddr);
        end
        @(posedge clk); #1;
        checks++;
        if ({pipe.done, pipe.adel, pipe.ades} !== 3'b000) begin
            errors++;
            $display("FAIL abort_no_pulse got done/adel/ades=%b%b%b exp=000",
                     pipe.done, pipe.adel, pipe.ades);
        end
        do_access(1'b0, 2'd2, 1'b0, 32'h80, 32'h0);
        expect_rdata("abort_word_intact", orig);
    endtask

    task automatic test_back_to_back();
        logic exp_ready;
        logic exp_done;
        @(negedge clk);
        pipe.req   = 1'b1;
        pipe.wr    = 1'b0;
        pipe.size  = 2'd2;
        pipe.uns   = 1'b0;
        pipe.vaddr = 32'h10;
        for (int c = 1; c <= 9; c++) begin
            @(posedge clk); #1;
            exp_ready = (c % 3 == 0);
            exp_done  = (c % 3 == 2);
            checks++;
            if ({pipe.ready, pipe.done} !== {exp_ready, exp_done}) begin
                errors++;
                $display("FAIL b2b_cycle%0d got rdy/done=%b%b exp=%b%b",
                         c, pipe.ready, pipe.done, exp_ready, exp_done);
            end
        end
        @(negedge clk);
        pipe.req = 1'b0;
        m_rdata  = model_load(2'd2, 1'b0, 12'h010);
        expect_rdata("b2b_rdata", m_rdata);
    endtask

    task automatic test_random();
        logic [1:0] sz;
        for (int it = 0; it < 300; it++) begin
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            do_access(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
                      {$urandom_range(0, 3) == 0 ? 20'($urandom) : 20'h0, 6'h0, 6'($urandom)},
                      $urandom);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_store_load_word();
        test_load_extend();
        test_partial_store();
        test_faults();
        test_wrap();
        test_reset_in_access();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
